// File: rtl/clkdiv_bank_pkg.sv
// Shared constants for the clkdiv_bank clock-enable generator.
// Divisors are half-periods in clk50M cycles: f_out = CLK_HZ / (2 * div).
package clkdiv_pkg;

  localparam int CLK_HZ        = 50_000_000;
  localparam int DEFAULT_CNT_W = 26;

  localparam int DIV_1HZ   = 25_000_000;
  localparam int DIV_1KHZ  = 25_000;
  localparam int DIV_1MHZ  = 25;
  localparam int DIV_25MHZ = 1;

  // Width of a channel index; a single-channel bank still gets one bit.
  function automatic int ch_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_bank_if.sv
// Configuration bus of clkdiv_bank: divisor write port plus, when
// CLKDIV_READBACK_EN is defined, the registered divisor readback and the
// pending flag of the addressed channel.
interface clkdiv_bank_if
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = DEFAULT_CNT_W
) ();

  localparam int CH_W = ch_idx_width(NUM_CH);

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
`ifdef CLKDIV_READBACK_EN
  logic [CNT_W-1:0] cfg_rdata;
  logic             cfg_pending;
`endif

`ifdef CLKDIV_READBACK_EN
  modport master (output cfg_we, cfg_ch, cfg_div, input cfg_rdata, cfg_pending);
  modport slave  (input cfg_we, cfg_ch, cfg_div, output cfg_rdata, cfg_pending);
`else
  modport master (output cfg_we, cfg_ch, cfg_div);
  modport slave  (input cfg_we, cfg_ch, cfg_div);
`endif

endinterface

// File: rtl/clkdiv_bank_channel.sv
// One divider channel: half-period counter, active divisor, shadow divisor
// with pending flag, and the registered divided wave / tick strobe.
// Optional macro CLKDIV_READBACK_EN exposes the active divisor and pending flag.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int               CNT_W     = DEFAULT_CNT_W,
  parameter logic [CNT_W-1:0] DIV_RESET = '0
) (
  input  logic             clk50M,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             we,
  input  logic [CNT_W-1:0] wdata,
`ifdef CLKDIV_READBACK_EN
  output logic [CNT_W-1:0] div_q,
  output logic             pending_q,
`endif
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] shadow;
  logic             pending;
  logic             running;
  logic             terminal;

  // The channel counts only when enabled, not being phase-aligned, and div != 0.
  assign running  = en && !sync && (div != '0);
  assign terminal = running && (cnt == div - CNT_W'(1));

  // Counter and outputs: idle forces everything low, terminal count toggles the wave.
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (!running) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (terminal) begin
      cnt     <= '0;
      clk_out <= ~clk_out;
      tick    <= ~clk_out;
    end else begin
      cnt     <= cnt + CNT_W'(1);
      tick    <= 1'b0;
    end
  end

  // Divisor update: a running channel defers new values to the end of the current half-period.
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      div     <= DIV_RESET;
      shadow  <= '0;
      pending <= 1'b0;
    end else if (we) begin
      if (!en || (div == '0) || terminal) begin
        div     <= wdata;
        pending <= 1'b0;
      end else begin
        shadow  <= wdata;
        pending <= 1'b1;
      end
    end else if (pending && terminal) begin
      div     <= shadow;
      pending <= 1'b0;
    end
  end

`ifdef CLKDIV_READBACK_EN
  assign div_q     = div;
  assign pending_q = pending;
`endif

endmodule

// File: rtl/clkdiv_bank.sv
// clkdiv_bank: NUM_CH programmable clock-enable / divided-clock channels on clk50M.
// Top level decodes divisor writes, fans out sync/ch_en, and (with macro
// CLKDIV_READBACK_EN defined) provides the registered divisor readback mux.
module clkdiv_bank
  import clkdiv_pkg::*;
#(
  parameter int                      NUM_CH   = 4,
  parameter int                      CNT_W    = DEFAULT_CNT_W,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {CNT_W'(DIV_1HZ), CNT_W'(DIV_1MHZ),
                                                 CNT_W'(DIV_25MHZ), CNT_W'(0)}
) (
  input  logic              clk50M,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  clkdiv_bank_if.slave      cfg,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam int CH_W = ch_idx_width(NUM_CH);

  logic [NUM_CH-1:0] ch_we;

  // Write decode; an index with no matching channel simply selects nothing.
  always_comb begin
    ch_we = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cfg.cfg_we && (cfg.cfg_ch == CH_W'(k))) begin
        ch_we[k] = 1'b1;
      end
    end
  end

`ifdef CLKDIV_READBACK_EN
  logic [CNT_W-1:0]  ch_div [NUM_CH];
  logic [NUM_CH-1:0] ch_pending;
  logic [CNT_W-1:0]  rd_sel;
  logic              pend_sel;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clkdiv_channel #(
      .CNT_W    (CNT_W),
      .DIV_RESET(DIV_INIT[k*CNT_W +: CNT_W])
    ) u_ch (
      .clk50M   (clk50M),
      .rst      (rst),
      .en       (ch_en[k]),
      .sync     (sync),
      .we       (ch_we[k]),
      .wdata    (cfg.cfg_div),
`ifdef CLKDIV_READBACK_EN
      .div_q    (ch_div[k]),
      .pending_q(ch_pending[k]),
`endif
      .clk_out  (clk_out[k]),
      .tick     (tick[k])
    );
  end

`ifdef CLKDIV_READBACK_EN
  // Readback select; an out-of-range index reads as zero.
  always_comb begin
    rd_sel   = '0;
    pend_sel = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cfg.cfg_ch == CH_W'(k)) begin
        rd_sel   = ch_div[k];
        pend_sel = ch_pending[k];
      end
    end
  end

  // Divisor readback is registered to keep the wide mux off the output path.
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      cfg.cfg_rdata <= '0;
    end else begin
      cfg.cfg_rdata <= rd_sel;
    end
  end

  assign cfg.cfg_pending = pend_sel;
`else
  // No readback path: channel divisors and pending flags stay internal.
`endif

endmodule

// File: tb/tb_clkdiv_bank.sv
// Self-checking bench for clkdiv_bank: directed phases with hand-computed tick
// times, a randomized phase, and an event-time reference model that predicts
// each channel's next toggle edge and is compared against the DUT every cycle.
module tb_clkdiv_bank;
  import clkdiv_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 26;

  logic              clk50M;
  logic              rst;
  logic [NUM_CH-1:0] ch_en;
  logic              sync;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  clkdiv_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg_bus ();

  clkdiv_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk50M (clk50M),
    .rst    (rst),
    .ch_en  (ch_en),
    .sync   (sync),
    .cfg    (cfg_bus),
    .clk_out(clk_out),
    .tick   (tick)
  );

  initial begin
    clk50M = 1'b0;
    forever #10 clk50M = ~clk50M;
  end

  int checks = 0;
  int errors = 0;
  int cyc;
  bit cmp_on = 1'b0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Edge counter since reset release, independent of the model.
  always @(posedge clk50M or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Reference model: each channel remembers the absolute edge of its next toggle.
  int unsigned m_div    [NUM_CH];
  int unsigned m_shadow [NUM_CH];
  bit          m_pend   [NUM_CH];
  bit          m_level  [NUM_CH];
  bit          m_tick   [NUM_CH];
  longint      m_due    [NUM_CH];
  longint      n;
  int unsigned init_div [NUM_CH] = '{0, 1, 25, 25_000_000};

  always @(posedge clk50M or posedge rst) begin
    if (rst) begin
      n = 0;
      for (int k = 0; k < NUM_CH; k++) begin
        m_div[k]    = init_div[k];
        m_shadow[k] = 0;
        m_pend[k]   = 1'b0;
        m_level[k]  = 1'b0;
        m_tick[k]   = 1'b0;
        m_due[k]    = longint'(init_div[k]);
      end
    end else begin
      n = n + 1;
      for (int k = 0; k < NUM_CH; k++) begin
        bit wr, act, tog;
        wr  = cfg_bus.cfg_we && (int'(cfg_bus.cfg_ch) == k);
        act = !sync && ch_en[k] && (m_div[k] != 0);
        tog = act && (m_due[k] == n);
        if (wr) begin
          if (!ch_en[k] || m_div[k] == 0 || tog) begin
            m_div[k]  = int'(cfg_bus.cfg_div);
            m_pend[k] = 1'b0;
          end else begin
            m_shadow[k] = int'(cfg_bus.cfg_div);
            m_pend[k]   = 1'b1;
          end
        end else if (m_pend[k] && tog) begin
          m_div[k]  = m_shadow[k];
          m_pend[k] = 1'b0;
        end
        if (!act) begin
          m_level[k] = 1'b0;
          m_tick[k]  = 1'b0;
          m_due[k]   = n + longint'(m_div[k]);
        end else if (tog) begin
          m_level[k] = !m_level[k];
          m_tick[k]  = m_level[k];
          m_due[k]   = n + longint'(m_div[k]);
        end else begin
          m_tick[k]  = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk50M) begin
    if (!rst && cmp_on) begin
      logic [NUM_CH-1:0] exp_c, exp_t;
      for (int k = 0; k < NUM_CH; k++) begin
        exp_c[k] = m_level[k];
        exp_t[k] = m_tick[k];
      end
      checkOutput("model_clk_out", clk_out, exp_c);
      checkOutput("model_tick", tick, exp_t);
    end
  end

  task automatic waitUntil(input int target);
    for (int i = 0; i < 5000 && cyc < target; i++) @(negedge clk50M);
  endtask

  task automatic waitTick(input int k, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk50M);
      if (tick[k]) begin
        at = cyc;
        return;
      end
    end
  endtask

  task automatic cfgWrite(input int ch, input int unsigned d);
    cfg_bus.cfg_we  = 1'b1;
    cfg_bus.cfg_ch  = 2'(ch);
    cfg_bus.cfg_div = CNT_W'(d);
    @(negedge clk50M);
    cfg_bus.cfg_we  = 1'b0;
  endtask

  // Randomized traffic: occasional writes, enable flips and sync pulses.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      cfg_bus.cfg_we  = ($urandom_range(0, 7) == 0);
      cfg_bus.cfg_ch  = 2'($urandom_range(0, NUM_CH - 1));
      cfg_bus.cfg_div = CNT_W'($urandom_range(0, 12));
      if ($urandom_range(0, 39) == 0) ch_en[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
      sync = ($urandom_range(0, 99) == 0);
      @(negedge clk50M);
    end
    cfg_bus.cfg_we = 1'b0;
    sync           = 1'b0;
    ch_en          = '1;
  endtask

  initial begin
    int at;
    int diff;
    rst             = 1'b1;
    ch_en           = 4'b1111;
    sync            = 1'b0;
    cfg_bus.cfg_we  = 1'b0;
    cfg_bus.cfg_ch  = 2'd2;
    cfg_bus.cfg_div = '0;
    repeat (3) @(negedge clk50M);
    checkOutput("reset_clk_out", clk_out, 0);
    checkOutput("reset_tick", tick, 0);
    rst    = 1'b0;
    cmp_on = 1'b1;

    @(negedge clk50M);
    checkOutput("ch1_first_high", clk_out[1], 1);
    checkOutput("ch1_first_tick", tick[1], 1);
    @(negedge clk50M);
    checkOutput("ch1_second_low", clk_out[1], 0);
    checkOutput("ch1_no_tick", tick[1], 0);
    checkOutput("ch0_idle", clk_out[0], 0);

    waitTick(2, 40, at);
    checkOutput("ch2_tick_25", at, 25);
    waitTick(2, 60, at);
    checkOutput("ch2_tick_75", at, 75);

    waitUntil(80);
    cfgWrite(2, 10);
    waitTick(2, 60, at);
    checkOutput("ch2_shadow_tick_110", at, 110);
    waitTick(2, 60, at);
    checkOutput("ch2_tick_130", at, 130);

    waitUntil(139);
    cfgWrite(2, 3);
    waitTick(2, 20, at);
    checkOutput("ch2_tc_write_tick_143", at, 143);
    waitTick(2, 20, at);
    checkOutput("ch2_tick_149", at, 149);

    waitUntil(160);
    ch_en[2] = 1'b0;
    @(negedge clk50M);
    checkOutput("ch2_disabled_low_a", clk_out[2], 0);
    waitUntil(162);
    cfgWrite(2, 25);
    waitUntil(165);
    checkOutput("ch2_disabled_low_b", clk_out[2], 0);
    waitUntil(167);
    ch_en[2] = 1'b1;
    waitTick(2, 40, at);
    checkOutput("ch2_reenable_tick_192", at, 192);

    waitUntil(195);
    cfgWrite(1, 4);
    cfgWrite(2, 4);
    waitUntil(230);
    sync = 1'b1;
    @(negedge clk50M);
    sync = 1'b0;
    waitTick(2, 20, at);
    checkOutput("sync_first_tick_235", at, 235);
    checkOutput("sync_ch1_tick_coincides", tick[1], 1);
    diff = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk50M);
      if (tick[1] != tick[2]) diff++;
    end
    checkOutput("sync_ticks_aligned", diff, 0);

    applyStimulus(1500);
    repeat (50) @(negedge clk50M);

    cfgWrite(1, 1);
    repeat (30) @(negedge clk50M);
    for (int i = 0; i < 50 && clk_out[1] != 1'b1; i++) @(negedge clk50M);
    #3 rst = 1'b1;
    #1;
    checkOutput("async_rst_clk_out", clk_out, 0);
    checkOutput("async_rst_tick", tick, 0);
    repeat (2) @(negedge clk50M);
    cfg_bus.cfg_ch = 2'd2;
    rst = 1'b0;
`ifdef CLKDIV_READBACK_EN
    @(negedge clk50M);
    checkOutput("readback_ch2_after_reset", cfg_bus.cfg_rdata, 25);
`endif
    waitTick(2, 40, at);
    checkOutput("ch2_tick_after_reset", at, 25);
    repeat (20) @(negedge clk50M);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
